// File: rtl/game_tone_decoder.sv
// ---------------------------------------------------------------------------
// game_tone_decoder
//
// Measures the period of an incoming square-wave tone and classifies it as one
// of the six scale notes Do..La (codes 0..5), or unknown/silence (code 7).
// A classification is accepted only after STABLE_CNT identical consecutive
// results. Prolonged silence (no rising edge for TIMEOUT_CYC cycles) forces
// the output back to "none".
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   tone_in      square-wave tone, asynchronous to clk
//   note_out     accepted note code: 0 Do .. 5 La, 7 none
//   note_valid   high while note_out holds an accepted code 0..5
//   note_change  one-cycle pulse each time note_out changes value
//   period_out   last measured period, in clk cycles
// ---------------------------------------------------------------------------
module game_tone_decoder #(
    parameter int clk_100Mhz  = 100_000_000,
    parameter int TOL_SHIFT   = 6,
    parameter int STABLE_CNT  = 3,
    parameter int TIMEOUT_CYC = clk_100Mhz / 100,
    parameter int CNT_W       = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tone_in,
    output logic [2:0]       note_out,
    output logic             note_valid,
    output logic             note_change,
    output logic [CNT_W-1:0] period_out
);

    localparam int NUM_NOTES = 6;
    localparam int RUN_W     = $clog2(STABLE_CNT + 1);

    localparam logic [2:0]       CODE_NONE    = 3'd7;
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [RUN_W-1:0] RUN_FULL     = RUN_W'(STABLE_CNT);
    localparam logic [RUN_W-1:0] RUN_ONE      = RUN_W'(1);

    // Scale note frequencies in Hz, Do..La.
    function automatic int note_freq(input int n);
        case (n)
            0:       note_freq = 523;
            1:       note_freq = 587;
            2:       note_freq = 659;
            3:       note_freq = 698;
            4:       note_freq = 783;
            default: note_freq = 880;
        endcase
    endfunction

    typedef enum logic {
        IDLE,       // no edge seen yet: the next pulse only starts counting
        MEASURE     // every pulse completes a period measurement
    } state_t;

    state_t             state_reg;
    logic               sync_ff1_reg;
    logic               sync_ff2_reg;
    logic               sync_prev_reg;
    logic               pulse_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               armed_reg;
    logic [2:0]         cand_reg;
    logic [RUN_W-1:0]   run_reg;

    logic [CNT_W-1:0]   period_next;
    logic               period_sat;
    logic [31:0]        period_ext;
    logic [NUM_NOTES-1:0] note_match;
    logic [2:0]         code_next;
    logic [RUN_W-1:0]   run_next;
    logic               accept_next;

    // Measured period is cnt+1, held at the counter ceiling once saturated.
    assign period_next = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + CNT_W'(1);
    assign period_sat  = (period_next == CNT_MAX);
    assign period_ext  = 32'(period_next);

    // One inclusive window comparator per note: |period - P| <= P >> TOL_SHIFT.
    generate
        for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_note
            localparam int          P_REF = clk_100Mhz / note_freq(gi);
            localparam int          TOL   = P_REF >> TOL_SHIFT;
            localparam logic [31:0] LO    = 32'(P_REF - TOL);
            localparam logic [31:0] HI    = 32'(P_REF + TOL);
            assign note_match[gi] = (period_ext >= LO) && (period_ext <= HI);
        end
    endgenerate

    // Lowest matching note wins: scan downward so the lowest index is written last.
    always_comb begin
        code_next = CODE_NONE;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            if (note_match[i]) begin
                code_next = 3'(i);
            end
        end
        if (period_sat) begin
            code_next = CODE_NONE;
        end
    end

    // Stability filter: the candidate always becomes the new code; the run
    // count grows only while the code repeats.
    always_comb begin
        run_next = RUN_ONE;
        if (code_next == cand_reg) begin
            run_next = (run_reg >= RUN_FULL) ? RUN_FULL : run_reg + RUN_ONE;
        end
        accept_next = (run_next == RUN_FULL) && (code_next != note_out);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            sync_ff1_reg  <= 1'b0;
            sync_ff2_reg  <= 1'b0;
            sync_prev_reg <= 1'b0;
            pulse_reg     <= 1'b0;
            cnt_reg       <= '0;
            armed_reg     <= 1'b1;
            cand_reg      <= CODE_NONE;
            run_reg       <= '0;
            note_out      <= CODE_NONE;
            note_valid    <= 1'b0;
            note_change   <= 1'b0;
            period_out    <= '0;
        end else begin
            // Two-flop synchronizer followed by a registered rising-edge pulse.
            sync_ff1_reg  <= tone_in;
            sync_ff2_reg  <= sync_ff1_reg;
            sync_prev_reg <= sync_ff2_reg;
            pulse_reg     <= sync_ff2_reg & ~sync_prev_reg;

            note_change   <= 1'b0;

            if (pulse_reg) begin
                // A pulse always wins over a coincident timeout.
                cnt_reg   <= '0;
                armed_reg <= 1'b1;
                case (state_reg)
                    IDLE: begin
                        state_reg <= MEASURE;
                    end
                    MEASURE: begin
                        period_out <= period_next;
                        cand_reg   <= code_next;
                        run_reg    <= run_next;
                        if (accept_next) begin
                            note_out    <= code_next;
                            note_valid  <= (code_next != CODE_NONE);
                            note_change <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end else begin
                if (cnt_reg != CNT_MAX) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                // Silence: fires once, then stays disarmed until the next pulse.
                if (armed_reg && (cnt_reg == TIMEOUT_LAST)) begin
                    armed_reg  <= 1'b0;
                    state_reg  <= IDLE;
                    cand_reg   <= CODE_NONE;
                    run_reg    <= '0;
                    note_out   <= CODE_NONE;
                    note_valid <= 1'b0;
                    if (note_out != CODE_NONE) begin
                        note_change <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
